// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode/writeback bus for the scoreboarded register file
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              ena;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wrel;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;
  logic              rpend_a;
  logic              rpend_b;
  logic [ADDR_W:0]   pend_cnt;

  // Pipeline side: drives requests, consumes read data and hazard bits
  modport master (
    output ena, we, waddr, wdata, wrel, rsv_en, rsv_addr, raddr_a, raddr_b,
    input  rdata_a, rdata_b, rpend_a, rpend_b, pend_cnt
  );

  // Register file side
  modport slave (
    input  ena, we, waddr, wdata, wrel, rsv_en, rsv_addr, raddr_a, raddr_b,
    output rdata_a, rdata_b, rpend_a, rpend_b, pend_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with write bypass and pending-write scoreboard
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input logic         clk,
  input logic         reset,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit BYP   = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  pending_q;
  logic [DEPTH-1:0]  pending_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;

  logic wr_ok;
  logic rel_ok;
  logic rsv_ok;
  logic set_new;
  logic clr_eff;
  logic hit_a;
  logic hit_b;
  logic relhit_a;
  logic relhit_b;

  // Qualify requests: disabled block or address 0 turns them into no-ops
  always_comb begin
    wr_ok   = bus.ena && bus.we && (bus.waddr != '0);
    rel_ok  = wr_ok && bus.wrel;
    rsv_ok  = bus.ena && bus.rsv_en && (bus.rsv_addr != '0);
    // Counter follows actual bit transitions: a set on an already-pending
    // register, a clear of a non-pending one, or a clear overridden by a
    // same-address set contributes nothing.
    set_new = rsv_ok && !pending_q[bus.rsv_addr];
    clr_eff = rel_ok && pending_q[bus.waddr] &&
              !(rsv_ok && (bus.rsv_addr == bus.waddr));
  end

  // Scoreboard next state; set is applied after clear so a new producer wins
  always_comb begin
    pending_d = pending_q;
    if (rel_ok) pending_d[bus.waddr] = 1'b0;
    if (rsv_ok) pending_d[bus.rsv_addr] = 1'b1;
    pending_d[0] = 1'b0;

    pend_cnt_d = pend_cnt_q;
    if (set_new && !clr_eff)
      pend_cnt_d = pend_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    else if (clr_eff && !set_new)
      pend_cnt_d = pend_cnt_q - {{ADDR_W{1'b0}}, 1'b1};
  end

  // Register array: reset clears everything, otherwise accept qualified writes
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // Scoreboard bits and their population count update on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  // Combinational read ports with optional same-cycle write forwarding
  always_comb begin
    hit_a    = BYP && wr_ok && (bus.waddr == bus.raddr_a);
    hit_b    = BYP && wr_ok && (bus.waddr == bus.raddr_b);
    relhit_a = BYP && rel_ok && (bus.waddr == bus.raddr_a);
    relhit_b = BYP && rel_ok && (bus.waddr == bus.raddr_b);

    bus.rdata_a = '0;
    bus.rdata_b = '0;
    bus.rpend_a = 1'b0;
    bus.rpend_b = 1'b0;
    if (bus.ena) begin
      if (bus.raddr_a != '0) bus.rdata_a = hit_a ? bus.wdata : regs_q[bus.raddr_a];
      if (bus.raddr_b != '0) bus.rdata_b = hit_b ? bus.wdata : regs_q[bus.raddr_b];
      bus.rpend_a = relhit_a ? 1'b0 : pending_q[bus.raddr_a];
      bus.rpend_b = relhit_b ? 1'b0 : pending_q[bus.raddr_b];
    end
  end

  assign bus.pend_cnt = pend_cnt_q;
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the CPU's general-purpose register file, sitting between decode and writeback in the pipelined MIPS core. It adds configurable data width and depth, a same-cycle write-to-read bypass, and a per-register pending-write scoreboard, so decode can detect RAW hazards without external tracking. All state changes occur on the rising edge of a single clock.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- BYPASS, 1, 1 = a read of the address being written returns the write data in the same cycle; 0 = the read returns the old contents

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; clears all registers, pending bits and pend_cnt
- ena  in  1  block enable; when 0, write, reserve and release are ignored and read data is forced to 0
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- wrel  in  1  when 1 with we, the write also clears pending[waddr]
- rsv_en  in  1  reserve request: set pending[rsv_addr]
- rsv_addr  in  ADDR_W  address to reserve
- raddr_a, raddr_b  in  ADDR_W  read addresses
- rdata_a, rdata_b  out  DATA_W  read data (combinational)
- rpend_a, rpend_b  out  1  pending bit of the addressed register (combinational)
- pend_cnt  out  ADDR_W+1  number of registers with pending set

## Operation
- Storage: DEPTH x DATA_W flops. Register 0 is hardwired to zero:
  - writes to address 0 are discarded
  - reserves to address 0 are discarded
  - pending[0] is always 0
- Reset (reset=1 at the edge, regardless of ena or any other input):
  - all registers become 0, all pending bits 0, pend_cnt 0
  - any simultaneous write or reserve is discarded
  - reset takes priority mid-operation
- Write: if ena && we && waddr!=0, then reg[waddr] <= wdata.
- Read data, per port:
  - ena=0: 0
  - raddr=0: 0
  - BYPASS=1, ena && we && waddr==raddr && raddr!=0: wdata
  - otherwise: reg[raddr]
- Read pending, per port:
  - ena=0: 0
  - BYPASS=1 and a releasing write (we && wrel) to the same address this cycle: 0
  - otherwise: pending[raddr]
- Scoreboard updates at the edge, both gated by ena and both ignoring address 0:
  - set: rsv_en sets pending[rsv_addr]
  - clear: we && wrel clears pending[waddr]
  - set and clear on the same address in the same cycle: set wins, so the address stays pending (a new producer is issued as the old one retires)
  - set and clear on different addresses: both apply
  - reserving an already-pending register leaves it pending; there is no nesting count
  - releasing a non-pending register has no effect
- pend_cnt equals the population count of the pending bits. It is a registered value, updated in the same edge as the bits: +1, -1, or unchanged, using the net change. It never exceeds DEPTH-1.
- Writes without wrel update data only and leave pending untouched (used by non-tracked producers such as mtc0-style paths).

## Timing
- Read latency is 0 cycles (combinational from raddr and the register array).
- Write latency: data is visible at the rdata outputs in the cycle after the edge. It is also visible in the same cycle when BYPASS=1.
- Reserve latency: rpend rises in the cycle after the edge that captured rsv_en. There is no bypass on reserve.
- Release latency: rpend falls the cycle after the edge. With BYPASS=1 it is already 0 in the write cycle.
- pend_cnt changes only at rising edges. After reset it reads 0 from the first cycle onward.
- Outputs after reset with no further stimulus: rdata_a = rdata_b = 0, rpend_a = rpend_b = 0, pend_cnt = 0.
- There is no handshake or backpressure. Every request is accepted in the cycle it is presented.

## Test plan
- Reset, then write 0xDEADBEEF to r5 with we=1 and raddr_a=5 in the same cycle: rdata_a=0xDEADBEEF in that cycle (BYPASS=1) or 0 (BYPASS=0). Both settings read 0xDEADBEEF the next cycle.
- Write 0x1234 to r0, then read r0: rdata=0. Reserve r0: rpend=0, pend_cnt stays 0.
- Reserve r3, then r7 on the next cycle: pend_cnt goes 1, then 2, and rpend for r3 is 1. Then write r3 with wrel=1 and data 0x55: rpend_a(r3)=0 and pend_cnt=1 after the edge, and rdata=0x55.
- In one cycle, reserve r9 and release-write r9 with data 0xA5: afterwards r9 reads 0xA5, rpend=1 and pend_cnt is unchanged (+0 net after the earlier reserve, +1 if r9 was not pending before).
- Drive ena=0 with a write to r4 of 0xFF and a reserve of r4: r4 stays at its prior value, pending is unchanged, and rdata/rpend outputs are 0 while ena=0.
- Fill r1..r31 with values and reserves, then assert reset for one edge while a write to r2 is active: all reads return 0, all pending bits are 0, and pend_cnt=0.
